// File: rtl/quad_enc_idx_if.sv
// Signal bundle for quad_enc_idx: raw encoder channels, control inputs and decoded results.
interface quad_enc_idx_if #(
    parameter int ENCBITS = 64,
    parameter int VELBITS = 32
);
    logic                      a;
    logic                      b;
    logic                      z;
    logic                      enable;
    logic [1:0]                mode;
    logic [7:0]                multiplier;
    logic                      clear;
    logic                      index_reset_en;
    logic [31:0]               vel_period;
    logic signed [ENCBITS-1:0] count;
    logic signed [ENCBITS-1:0] index_count;
    logic                      index_seen;
    logic                      faultn;
    logic [7:0]                fault_cnt;
    logic signed [VELBITS-1:0] velocity;
    logic                      vel_valid;

    modport master (
        output a, b, z, enable, mode, multiplier, clear, index_reset_en, vel_period,
        input  count, index_count, index_seen, faultn, fault_cnt, velocity, vel_valid
    );

    modport slave (
        input  a, b, z, enable, mode, multiplier, clear, index_reset_en, vel_period,
        output count, index_count, index_seen, faultn, fault_cnt, velocity, vel_valid
    );
endinterface

// File: rtl/quad_enc_idx.sv
// Quadrature encoder decoder with index capture, fault tracking and windowed velocity.
// Channels are synchronised and persistence-filtered before x4/x2/x1 step decoding.
module quad_enc_idx #(
    parameter int ENCBITS = 64,
    parameter int FILT    = 3,
    parameter int VELBITS = 32
) (
    input  logic          clk,
    input  logic          reset,
    quad_enc_idx_if.slave bus
);
    localparam logic [3:0] FILT_LAST = 4'(FILT - 1);
    localparam logic signed [VELBITS-1:0] VEL_MAX = {1'b0, {(VELBITS-1){1'b1}}};
    localparam logic signed [VELBITS-1:0] VEL_MIN = {1'b1, {(VELBITS-1){1'b0}}};

    function automatic logic signed [VELBITS-1:0] sat_add(
        input logic signed [VELBITS-1:0] x,
        input logic signed [VELBITS-1:0] y
    );
        logic signed [VELBITS:0] sum;
        sum = {x[VELBITS-1], x} + {y[VELBITS-1], y};
        if (sum[VELBITS] != sum[VELBITS-1]) begin
            sat_add = sum[VELBITS] ? VEL_MIN : VEL_MAX;
        end else begin
            sat_add = sum[VELBITS-1:0];
        end
    endfunction

    // Bit 0 = A, bit 1 = B, bit 2 = Z throughout the front end.
    logic [2:0]                raw_s;
    logic [2:0]                sync1_r;
    logic [2:0]                sync2_r;
    logic [2:0]                filt_r;
    logic [2:0]                filt_d_r;
    logic [2:0]                chg_s;
    logic [3:0]                fcnt_r [3];
    logic                      step_s;
    logic                      fwd_s;
    logic                      fault_s;
    logic                      idx_evt_s;
    logic                      idx_rst_s;
    logic                      apply_s;
    logic signed [ENCBITS-1:0] cdelta_s;
    logic signed [VELBITS-1:0] vdelta_s;
    logic signed [ENCBITS-1:0] count_r;
    logic signed [ENCBITS-1:0] index_count_r;
    logic                      index_seen_r;
    logic                      faultn_r;
    logic [7:0]                fault_cnt_r;
    logic [31:0]               win_r;
    logic signed [VELBITS-1:0] acc_r;
    logic signed [VELBITS-1:0] velocity_r;
    logic                      vel_valid_r;

    assign raw_s = {bus.z, bus.b, bus.a};

    // Synchronisers, persistence filters and the one-cycle delayed filtered copy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r  <= 3'b000;
            sync2_r  <= 3'b000;
            filt_r   <= 3'b000;
            filt_d_r <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                fcnt_r[i] <= 4'd0;
            end
        end else begin
            sync1_r  <= raw_s;
            sync2_r  <= sync1_r;
            filt_d_r <= filt_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == filt_r[i]) begin
                    fcnt_r[i] <= 4'd0;
                end else if (fcnt_r[i] == FILT_LAST) begin
                    filt_r[i] <= sync2_r[i];
                    fcnt_r[i] <= 4'd0;
                end else begin
                    fcnt_r[i] <= fcnt_r[i] + 4'd1;
                end
            end
        end
    end

    assign chg_s = filt_r ^ filt_d_r;
    assign fwd_s = filt_r[0] ^ filt_d_r[1];

    // Mode-dependent step qualification
    always_comb begin
        step_s = 1'b0;
        case (bus.mode)
            2'd1:    step_s = chg_s[0] & ~chg_s[1];
            2'd2:    step_s = chg_s[0] & filt_r[0] & ~chg_s[1];
            default: step_s = chg_s[0] ^ chg_s[1];
        endcase
    end

    assign fault_s   = bus.enable & chg_s[0] & chg_s[1];
    assign idx_evt_s = bus.enable & filt_r[2] & ~filt_d_r[2];
    assign idx_rst_s = idx_evt_s & bus.index_reset_en;
    // A step only lands when neither clear nor an index reset overrides it
    assign apply_s   = bus.enable & step_s & ~bus.clear & ~idx_rst_s;
    assign cdelta_s  = fwd_s ? ENCBITS'(bus.multiplier) : -ENCBITS'(bus.multiplier);
    assign vdelta_s  = apply_s ? (fwd_s ? VELBITS'(bus.multiplier) : -VELBITS'(bus.multiplier))
                               : {VELBITS{1'b0}};

    // Position count, sticky fault state and index-seen flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r      <= {ENCBITS{1'b0}};
            faultn_r     <= 1'b1;
            fault_cnt_r  <= 8'd0;
            index_seen_r <= 1'b0;
        end else if (bus.clear) begin
            count_r      <= {ENCBITS{1'b0}};
            faultn_r     <= 1'b1;
            fault_cnt_r  <= 8'd0;
            index_seen_r <= 1'b0;
        end else begin
            if (idx_rst_s) begin
                count_r <= {ENCBITS{1'b0}};
            end else if (apply_s) begin
                count_r <= count_r + cdelta_s;
            end
            if (fault_s) begin
                faultn_r <= 1'b0;
                if (fault_cnt_r != 8'hFF) begin
                    fault_cnt_r <= fault_cnt_r + 8'd1;
                end
            end
            if (idx_evt_s) begin
                index_seen_r <= 1'b1;
            end
        end
    end

    // Index capture samples the count as it stood before this cycle's update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_count_r <= {ENCBITS{1'b0}};
        end else if (idx_evt_s) begin
            index_count_r <= count_r;
        end
    end

    // Velocity window timer and saturating step accumulator
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_r       <= 32'd0;
            acc_r       <= {VELBITS{1'b0}};
            velocity_r  <= {VELBITS{1'b0}};
            vel_valid_r <= 1'b0;
        end else if (bus.vel_period == 32'd0) begin
            win_r       <= 32'd0;
            acc_r       <= {VELBITS{1'b0}};
            vel_valid_r <= 1'b0;
        end else if (win_r >= bus.vel_period - 32'd1) begin
            win_r       <= 32'd0;
            acc_r       <= {VELBITS{1'b0}};
            velocity_r  <= sat_add(acc_r, vdelta_s);
            vel_valid_r <= 1'b1;
        end else begin
            win_r       <= win_r + 32'd1;
            acc_r       <= sat_add(acc_r, vdelta_s);
            vel_valid_r <= 1'b0;
        end
    end

    assign bus.count       = count_r;
    assign bus.index_count = index_count_r;
    assign bus.index_seen  = index_seen_r;
    assign bus.faultn      = faultn_r;
    assign bus.fault_cnt   = fault_cnt_r;
    assign bus.velocity    = velocity_r;
    assign bus.vel_valid   = vel_valid_r;
endmodule

// File: doc/quad_enc_idx.md
QUAD_ENC_IDX -- requirements
Module: quad_enc_idx

Interface
REQ-001 Parameter ENCBITS, default 64; position counter width.
REQ-002 Parameter FILT, default 3, legal 1..15; number of consecutive identical synchronised samples required before a filtered level changes.
REQ-003 Parameter VELBITS, default 32; velocity accumulator and output width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 a, b, z  input  1 each  raw encoder channels A, B and index; asynchronous to clk.
REQ-007 enable  input  1  when 0, steps, index events and faults are ignored; synchronisers and filters keep running.
REQ-008 mode  input  2  decode mode: 0 = x4, 1 = x2, 2 = x1, 3 = x4.
REQ-009 multiplier  input  8  unsigned step weight, zero-extended to ENCBITS.
REQ-010 clear  input  1  synchronous clear of count, fault state and index_seen.
REQ-011 index_reset_en  input  1  when 1, a filtered z rising edge zeroes count.
REQ-012 vel_period  input  32  velocity window length in clk cycles; 0 disables velocity.
REQ-013 count  output  ENCBITS signed  position.
REQ-014 index_count  output  ENCBITS signed  count captured at last index edge.
REQ-015 index_seen  output  1  sticky; set on first index edge.
REQ-016 faultn  output  1  sticky active-low fault flag.
REQ-017 fault_cnt  output  8  saturating fault event counter.
REQ-018 velocity  output  VELBITS signed  net weighted steps in last completed window.
REQ-019 vel_valid  output  1  one-cycle pulse when velocity updates.

Function
REQ-020 Each of a, b, z passes through a 2-flop synchroniser, then a filter whose output takes the synchronised value only after FILT consecutive identical samples that differ from the current filtered value.
REQ-021 Edge detection compares the filtered value with its one-cycle-delayed copy; step_a/step_b/step_z are the respective changes.
REQ-022 Direction is forward when new filtered A differs from previous filtered B; forward adds multiplier, reverse subtracts it.
REQ-023 x4: a step occurs when exactly one of step_a, step_b is set.
REQ-024 x2: a step occurs only on step_a with step_b clear.
REQ-025 x1: a step occurs only on a rising filtered A with step_b clear.
REQ-026 step_a and step_b in the same cycle is a fault: faultn <= 0, fault_cnt increments and saturates at 255, and count is unchanged.
REQ-027 Latency from a raw input transition to its count update is FILT+3 clk cycles.
REQ-028 count wraps modulo 2^ENCBITS with no saturation and no fault.
REQ-029 Filtered z rising edge with enable=1: index_count <= count value before this cycle's update, and index_seen <= 1.
REQ-030 If index_reset_en=1 on that index edge, count <= 0 and any same-cycle step is discarded.
REQ-031 Same-cycle priority: reset > clear > index reset > step.
REQ-032 clear sets count=0, faultn=1, fault_cnt=0 and index_seen=0; it does not affect index_count, velocity or the velocity window.
REQ-033 Velocity window: a cycle counter runs 0..vel_period-1 while the signed accumulator sums each applied step's signed weight.
REQ-034 On the terminal cycle, velocity <= accumulator plus that cycle's delta, the accumulator restarts at 0, and vel_valid pulses for one cycle.
REQ-035 The accumulator saturates at the signed VELBITS limits.
REQ-036 Writing vel_period=0 holds the window counter and accumulator at 0 and keeps vel_valid at 0; velocity retains its last value.
REQ-037 A vel_period change takes effect at the next compare; if the counter is already >= the new value, the window terminates immediately.
REQ-038 enable=0 holds count, fault state and index state; the velocity window keeps timing but accumulates 0.

Reset
REQ-039 reset=1 asynchronously forces count=0, index_count=0, index_seen=0, faultn=1, fault_cnt=0, velocity=0, vel_valid=0, and clears all synchroniser, filter, edge and window state.
REQ-040 Filter state after reset is 0, so inputs held high at reset release produce one rising edge FILT+3 cycles after release.

Verification
REQ-041 x4, multiplier=1, FILT=3, 8 forward quadrature edges spaced 10 cycles -> count=8; first increment 6 cycles after first edge.
REQ-042 x1, multiplier=4, 2 full reverse cycles -> count=-8; x2 over the same stimulus -> count=-16.
REQ-043 a and b toggled in the same clk -> faultn=0, fault_cnt=1, count unchanged; then clear -> faultn=1, fault_cnt=0.
REQ-044 2-cycle glitch on a with FILT=3 -> no count change and no fault.
REQ-045 count=0x7FFF_FFFF_FFFF_FFFF, one forward step -> count=0x8000_0000_0000_0000; index edge with index_reset_en=1 coinciding with a step -> count=0 and index_count holds the pre-edge value.
REQ-046 vel_period=100, 5 forward steps within a window -> vel_valid pulses every 100 cycles and velocity=5; reset asserted mid-window -> all outputs return to reset values.
